// File: rtl/pe_round_scheduler_if.sv
// Bundle of go/config, PE start/done, shared-memory request/grant and status signals
// exchanged between the round scheduler and its controller / PE array.
interface pe_round_scheduler_if #(
    parameter int NUM_PE  = 5,
    parameter int ROUND_W = 5
);
    logic               go;
    logic [ROUND_W-1:0] cfg_rounds;
    logic [NUM_PE-1:0]  cfg_pe_mask;
    logic [NUM_PE-1:0]  pe_start;
    logic [NUM_PE-1:0]  pe_done;
    logic [NUM_PE-1:0]  mem_req;
    logic [NUM_PE-1:0]  mem_gnt;
    logic               busy;
    logic [ROUND_W-1:0] round_idx;
    logic               all_done;
    logic               err;

    modport master (
        output go, cfg_rounds, cfg_pe_mask, pe_done, mem_req,
        input  pe_start, mem_gnt, busy, round_idx, all_done, err
    );

    modport slave (
        input  go, cfg_rounds, cfg_pe_mask, pe_done, mem_req,
        output pe_start, mem_gnt, busy, round_idx, all_done, err
    );
endinterface

// File: rtl/pe_round_scheduler.sv
// Round sequencer for the PE array plus a round-robin arbiter for the shared memory port.
// All outputs come straight from flops; the arbiter runs independently of the round FSM.
module pe_round_scheduler #(
    parameter int NUM_PE  = 5,
    parameter int ROUND_W = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    pe_round_scheduler_if.slave bus
);
    localparam int IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        RUN,
        ADVANCE,
        FINISH
    } state_t;

    state_t             state;
    logic [NUM_PE-1:0]  mask;
    logic [NUM_PE-1:0]  done_vec;
    logic [ROUND_W-1:0] rounds_left;
    logic [NUM_PE-1:0]  pe_start_r;
    logic [ROUND_W-1:0] round_idx_r;
    logic               busy_r;
    logic               all_done_r;
    logic               err_r;

    logic [NUM_PE-1:0]  done_in;
    logic [NUM_PE-1:0]  done_merged;
    logic               go_accept;
    logic               err_event;

    assign done_in     = bus.pe_done & mask;
    assign done_merged = done_vec | done_in;
    assign go_accept   = (state == IDLE) && bus.go;

    // Stray, unmasked or repeated done pulses are flagged but otherwise ignored.
    assign err_event = (state != RUN) ? (|bus.pe_done)
                     : ((|(bus.pe_done & ~mask)) || (|(bus.pe_done & done_vec)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mask        <= '0;
            done_vec    <= '0;
            rounds_left <= '0;
            pe_start_r  <= '0;
            round_idx_r <= '0;
            busy_r      <= 1'b0;
            all_done_r  <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            pe_start_r <= '0;
            all_done_r <= 1'b0;
            err_r      <= (go_accept ? 1'b0 : err_r) | err_event;
            case (state)
                IDLE: begin
                    if (bus.go) begin
                        mask        <= bus.cfg_pe_mask;
                        rounds_left <= bus.cfg_rounds;
                        done_vec    <= '0;
                        round_idx_r <= '0;
                        busy_r      <= 1'b1;
                        if ((bus.cfg_rounds == '0) || (bus.cfg_pe_mask == '0)) begin
                            state      <= FINISH;
                            all_done_r <= 1'b1;
                        end else begin
                            state      <= START;
                            pe_start_r <= bus.cfg_pe_mask;
                        end
                    end
                end
                START: begin
                    state <= RUN;
                end
                RUN: begin
                    done_vec <= done_merged;
                    if (done_merged == mask) begin
                        state <= ADVANCE;
                    end
                end
                ADVANCE: begin
                    done_vec    <= '0;
                    rounds_left <= rounds_left - ROUND_W'(1);
                    if (rounds_left == ROUND_W'(1)) begin
                        state      <= FINISH;
                        all_done_r <= 1'b1;
                    end else begin
                        round_idx_r <= round_idx_r + ROUND_W'(1);
                        state       <= START;
                        pe_start_r  <= mask;
                    end
                end
                FINISH: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pe_start  = pe_start_r;
    assign bus.busy      = busy_r;
    assign bus.round_idx = round_idx_r;
    assign bus.all_done  = all_done_r;
    assign bus.err       = err_r;

    logic [NUM_PE-1:0] gnt_r;
    logic [IDX_W-1:0]  owner;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  winner;
    logic              found;

    // First requester at or above rr_ptr, wrapping around the PE count.
    always_comb begin
        int cand;
        logic [IDX_W-1:0] cand_idx;
        found    = 1'b0;
        winner   = '0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= NUM_PE) begin
                cand = cand - NUM_PE;
            end
            cand_idx = IDX_W'(cand);
            if (!found && bus.mem_req[cand_idx]) begin
                found  = 1'b1;
                winner = cand_idx;
            end
        end
    end

    // A release always leaves one empty grant cycle before the next owner is chosen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_r  <= '0;
            owner  <= '0;
            rr_ptr <= '0;
        end else if (|gnt_r) begin
            if (!bus.mem_req[owner]) begin
                gnt_r <= '0;
            end
        end else if (found) begin
            gnt_r  <= {{(NUM_PE-1){1'b0}}, 1'b1} << winner;
            owner  <= winner;
            rr_ptr <= (winner == IDX_W'(NUM_PE - 1)) ? '0 : winner + IDX_W'(1);
        end
    end

    assign bus.mem_gnt = gnt_r;
endmodule

// File: tb/tb_pe_round_scheduler.sv
// Directed self-checking bench for pe_round_scheduler: round sequencing, protocol
// error flagging, round-robin memory arbitration and asynchronous reset.
module tb_pe_round_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    pe_round_scheduler_if #(.NUM_PE(5), .ROUND_W(5)) bus ();

    pe_round_scheduler #(.NUM_PE(5), .ROUND_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.go = 1'b0; bus.cfg_rounds = '0; bus.cfg_pe_mask = '0;
        bus.pe_done = '0; bus.mem_req = '0;
        rst_n = 1'b0;
        tick(); tick();
        tests++;
        if ({bus.pe_start, bus.mem_gnt, bus.busy, bus.round_idx, bus.all_done, bus.err} !== '0) begin
            fails++;
            $display("[TB] FAIL reset_outputs: got start=%b gnt=%b busy=%b idx=%0d done=%b err=%b, expected all zero",
                     bus.pe_start, bus.mem_gnt, bus.busy, bus.round_idx, bus.all_done, bus.err);
        end
        rst_n = 1'b1;
        tick();
        tests++;
        if (bus.busy !== 1'b0) begin
            fails++; $display("[TB] FAIL reset_idle_busy: got %b expected 0", bus.busy);
        end
    endtask

    task automatic test_full_rounds();
        for (int r = 0; r < 3; r++) begin
            if (r == 0) begin
                bus.go = 1'b1; bus.cfg_rounds = 5'd3; bus.cfg_pe_mask = 5'b11111;
                tick();
                bus.go = 1'b0;
            end
            tests++;
            if (bus.pe_start !== 5'b11111 || bus.round_idx !== 5'(r)) begin
                fails++;
                $display("[TB] FAIL full_start_r%0d: got start=%b idx=%0d expected start=11111 idx=%0d",
                         r, bus.pe_start, bus.round_idx, r);
            end
            tick(); tick(); tick();
            bus.pe_done = 5'b11111;
            tick();
            bus.pe_done = '0;
            tests++;
            if (bus.pe_start !== 5'b00000 || bus.busy !== 1'b1 || bus.all_done !== 1'b0) begin
                fails++;
                $display("[TB] FAIL full_advance_r%0d: got start=%b busy=%b done=%b expected 00000 1 0",
                         r, bus.pe_start, bus.busy, bus.all_done);
            end
            tick();
        end
        tests++;
        if (bus.all_done !== 1'b1 || bus.round_idx !== 5'd2 || bus.err !== 1'b0 || bus.pe_start !== 5'b0) begin
            fails++;
            $display("[TB] FAIL full_finish: got done=%b idx=%0d err=%b start=%b expected 1 2 0 00000",
                     bus.all_done, bus.round_idx, bus.err, bus.pe_start);
        end
        tick();
        tests++;
        if (bus.all_done !== 1'b0 || bus.busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL full_idle: got done=%b busy=%b expected 0 0", bus.all_done, bus.busy);
        end
    endtask

    task automatic test_partial_mask();
        bus.go = 1'b1; bus.cfg_rounds = 5'd2; bus.cfg_pe_mask = 5'b00101;
        tick();
        tests++;
        if (bus.pe_start !== 5'b00101) begin
            fails++; $display("[TB] FAIL partial_start0: got %b expected 00101", bus.pe_start);
        end
        bus.go = 1'b1; bus.cfg_rounds = 5'd7; bus.cfg_pe_mask = 5'b11111;
        tick();
        bus.go = 1'b0;
        bus.pe_done = 5'b00001;
        tick();
        bus.pe_done = '0;
        for (int c = 0; c < 2; c++) begin
            tests++;
            if (bus.pe_start !== 5'b00000) begin
                fails++; $display("[TB] FAIL partial_early_advance%0d: got start=%b expected 00000", c, bus.pe_start);
            end
            tick();
        end
        bus.pe_done = 5'b00100;
        tick();
        bus.pe_done = '0;
        tests++;
        if (bus.pe_start !== 5'b00000 || bus.round_idx !== 5'd0) begin
            fails++;
            $display("[TB] FAIL partial_advance: got start=%b idx=%0d expected 00000 0", bus.pe_start, bus.round_idx);
        end
        tick();
        tests++;
        if (bus.pe_start !== 5'b00101 || bus.round_idx !== 5'd1) begin
            fails++;
            $display("[TB] FAIL partial_start1: got start=%b idx=%0d expected 00101 1", bus.pe_start, bus.round_idx);
        end
        tick();
        bus.pe_done = 5'b00101;
        tick();
        bus.pe_done = '0;
        tick();
        tests++;
        if (bus.all_done !== 1'b1 || bus.err !== 1'b0) begin
            fails++;
            $display("[TB] FAIL partial_finish: got done=%b err=%b expected 1 0", bus.all_done, bus.err);
        end
        tick();
    endtask

    task automatic test_zero_rounds();
        bus.go = 1'b1; bus.cfg_rounds = 5'd0; bus.cfg_pe_mask = 5'b11111;
        tick();
        tests++;
        if (bus.all_done !== 1'b1 || bus.busy !== 1'b1 || bus.pe_start !== 5'b0) begin
            fails++;
            $display("[TB] FAIL zero_finish: got done=%b busy=%b start=%b expected 1 1 00000",
                     bus.all_done, bus.busy, bus.pe_start);
        end
        bus.go = 1'b1; bus.cfg_rounds = 5'd2;
        tick();
        bus.go = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tests++;
            if (bus.busy !== 1'b0 || bus.pe_start !== 5'b0 || bus.all_done !== 1'b0) begin
                fails++;
                $display("[TB] FAIL zero_busy_go_ignored%0d: got busy=%b start=%b done=%b expected 0 00000 0",
                         c, bus.busy, bus.pe_start, bus.all_done);
            end
            tick();
        end
    endtask

    task automatic test_protocol_err();
        bus.go = 1'b1; bus.cfg_rounds = 5'd1; bus.cfg_pe_mask = 5'b11111;
        tick();
        bus.go = 1'b0;
        tick();
        bus.pe_done = 5'b00010;
        tick();
        tests++;
        if (bus.err !== 1'b0) begin
            fails++; $display("[TB] FAIL err_first_done: got %b expected 0", bus.err);
        end
        tick();
        tests++;
        if (bus.err !== 1'b1) begin
            fails++; $display("[TB] FAIL err_duplicate: got %b expected 1", bus.err);
        end
        bus.pe_done = 5'b11101;
        tick();
        bus.pe_done = '0;
        tick();
        tests++;
        if (bus.all_done !== 1'b1 || bus.err !== 1'b1) begin
            fails++;
            $display("[TB] FAIL err_round_completes: got done=%b err=%b expected 1 1", bus.all_done, bus.err);
        end
        tick(); tick();
        tests++;
        if (bus.err !== 1'b1) begin
            fails++; $display("[TB] FAIL err_sticky: got %b expected 1", bus.err);
        end
        bus.go = 1'b1; bus.cfg_rounds = 5'd0; bus.cfg_pe_mask = 5'b00001;
        tick();
        bus.go = 1'b0;
        tests++;
        if (bus.err !== 1'b0) begin
            fails++; $display("[TB] FAIL err_clear_on_go: got %b expected 0", bus.err);
        end
        tick();
        bus.pe_done = 5'b01000;
        tick();
        bus.pe_done = '0;
        tests++;
        if (bus.err !== 1'b1) begin
            fails++; $display("[TB] FAIL err_done_in_idle: got %b expected 1", bus.err);
        end
        bus.go = 1'b1; bus.cfg_rounds = 5'd1; bus.cfg_pe_mask = 5'b00001;
        tick();
        bus.go = 1'b0;
        tick();
        bus.pe_done = 5'b00010;
        tick();
        bus.pe_done = 5'b00001;
        tests++;
        if (bus.err !== 1'b1) begin
            fails++; $display("[TB] FAIL err_unmasked_done: got %b expected 1", bus.err);
        end
        tick();
        bus.pe_done = '0;
        tick();
        tests++;
        if (bus.all_done !== 1'b1) begin
            fails++; $display("[TB] FAIL err_unmasked_completes: got %b expected 1", bus.all_done);
        end
        tick();
    endtask

    task automatic test_arbiter();
        int order[4];
        int expect_order[4] = '{1, 2, 4, 1};
        int n = 0;
        int held = 0;
        int idx;
        logic [4:0] req = 5'b10110;
        logic [4:0] prev_g = 5'b0;
        logic [4:0] g;
        bus.mem_req = req;
        for (int cyc = 0; cyc < 60 && n < 4; cyc++) begin
            tick();
            g = bus.mem_gnt;
            if (cyc == 0) begin
                tests++;
                if (g !== 5'b00010) begin
                    fails++; $display("[TB] FAIL arb_latency: got %b expected 00010", g);
                end
            end
            tests++;
            if ($countones(g) > 1) begin
                fails++; $display("[TB] FAIL arb_onehot: got %b expected at most one bit", g);
            end
            if (g != 5'b0) begin
                if (g != prev_g) begin
                    tests++;
                    if (prev_g !== 5'b0) begin
                        fails++; $display("[TB] FAIL arb_idle_gap: got %b then %b expected a zero cycle", prev_g, g);
                    end
                    idx = 0;
                    for (int b = 0; b < 5; b++) if (g[b]) idx = b;
                    order[n] = idx;
                    n++;
                    held = 0;
                end
                held++;
                if (held == 3) req[idx] = 1'b0;
            end else begin
                req = 5'b10110;
            end
            bus.mem_req = req;
            prev_g = g;
        end
        tests++;
        if (n < 4) begin
            fails++; $display("[TB] FAIL arb_timeout: got %0d grants expected 4", n);
        end else begin
            for (int k = 0; k < 4; k++) begin
                tests++;
                if (order[k] !== expect_order[k]) begin
                    fails++; $display("[TB] FAIL arb_order%0d: got PE%0d expected PE%0d", k, order[k], expect_order[k]);
                end
            end
        end
        bus.mem_req = '0;
        tick(); tick();
        tests++;
        if (bus.mem_gnt !== 5'b0) begin
            fails++; $display("[TB] FAIL arb_release: got %b expected 00000", bus.mem_gnt);
        end
    endtask

    task automatic test_reset_mid_job();
        bus.mem_req = 5'b00001;
        bus.go = 1'b1; bus.cfg_rounds = 5'd3; bus.cfg_pe_mask = 5'b11111;
        tick();
        bus.go = 1'b0;
        tick();
        bus.pe_done = 5'b11111;
        tick();
        bus.pe_done = '0;
        tick();
        tick();
        tests++;
        if (bus.busy !== 1'b1 || bus.round_idx !== 5'd1 || bus.mem_gnt !== 5'b00001) begin
            fails++;
            $display("[TB] FAIL midjob_pre: got busy=%b idx=%0d gnt=%b expected 1 1 00001",
                     bus.busy, bus.round_idx, bus.mem_gnt);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({bus.pe_start, bus.mem_gnt, bus.busy, bus.round_idx, bus.all_done, bus.err} !== '0) begin
            fails++;
            $display("[TB] FAIL midjob_reset: got start=%b gnt=%b busy=%b idx=%0d done=%b err=%b expected all zero",
                     bus.pe_start, bus.mem_gnt, bus.busy, bus.round_idx, bus.all_done, bus.err);
        end
        bus.mem_req = '0;
        tick();
        rst_n = 1'b1;
        tick();
        bus.go = 1'b1; bus.cfg_rounds = 5'd1; bus.cfg_pe_mask = 5'b00011;
        tick();
        bus.go = 1'b0;
        tests++;
        if (bus.pe_start !== 5'b00011 || bus.round_idx !== 5'd0) begin
            fails++;
            $display("[TB] FAIL midjob_restart: got start=%b idx=%0d expected 00011 0", bus.pe_start, bus.round_idx);
        end
        tick();
        bus.pe_done = 5'b00011;
        tick();
        bus.pe_done = '0;
        tick();
        tests++;
        if (bus.all_done !== 1'b1) begin
            fails++; $display("[TB] FAIL midjob_finish: got %b expected 1", bus.all_done);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_full_rounds();
        test_partial_mask();
        test_zero_rounds();
        test_protocol_err();
        test_arbiter();
        test_reset_mid_job();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
